// File: rtl/uart_tx_framer_if.sv
// Handshake bundle between a byte source and the 8N1 UART transmit framer.
interface uart_tx_framer_if #(
    parameter int DBIT = 8
) ();
    logic            tx_start;
    logic [DBIT-1:0] tx_din;
    logic            tx;
    logic            tx_busy;
    logic            tx_done_tick;

    modport master (
        output tx_start, tx_din,
        input  tx, tx_busy, tx_done_tick
    );

    modport slave (
        input  tx_start, tx_din,
        output tx, tx_busy, tx_done_tick
    );
endinterface

// File: rtl/uart_tx_framer.sv
// 8N1 UART transmitter with its own 16x-oversample baud tick generator.
// One frame per accepted tx_start: start bit, DBIT data bits LSB first, stop.
module uart_tx_framer #(
    parameter int DBIT     = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 651,
    parameter int DIV_W    = 10
) (
    input  logic             clk_100MHz,
    input  logic             reset_n,
    uart_tx_framer_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t          state;
    logic [DIV_W-1:0] div_cnt;
    logic [4:0]      s_cnt;
    logic [3:0]      n_cnt;
    logic [DBIT-1:0] shift_reg;
    logic [DBIT-1:0] shift_next;
    logic            tx_reg;
    logic            busy_reg;
    logic            s_tick;
    logic            accept;
    logic            bit_end;
    logic            stop_end;

    assign s_tick     = (div_cnt == DIV_W'(BAUD_DIV - 1));
    assign accept     = (state == IDLE) && bus.tx_start;
    assign bit_end    = s_tick && (s_cnt == 5'd15);
    assign stop_end   = s_tick && (s_cnt == 5'(SB_TICK - 1));
    assign shift_next = shift_reg >> 1;

    // Restarting the divider on acceptance pins the frame timing to tx_start.
    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt <= '0;
        end else if (accept || s_tick) begin
            div_cnt <= '0;
        end else begin
            div_cnt <= div_cnt + DIV_W'(1);
        end
    end

    always_ff @(posedge clk_100MHz or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            s_cnt     <= '0;
            n_cnt     <= '0;
            shift_reg <= '0;
            tx_reg    <= 1'b1;
            busy_reg  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    tx_reg   <= 1'b1;
                    busy_reg <= 1'b0;
                    if (bus.tx_start) begin
                        shift_reg <= bus.tx_din;
                        s_cnt     <= '0;
                        tx_reg    <= 1'b0;
                        busy_reg  <= 1'b1;
                        state     <= START;
                    end
                end
                START: begin
                    if (bit_end) begin
                        s_cnt  <= '0;
                        n_cnt  <= '0;
                        tx_reg <= shift_reg[0];
                        state  <= DATA;
                    end else if (s_tick) begin
                        s_cnt <= s_cnt + 5'd1;
                    end
                end
                DATA: begin
                    if (bit_end) begin
                        s_cnt     <= '0;
                        shift_reg <= shift_next;
                        n_cnt     <= n_cnt + 4'd1;
                        // tx is registered, so load the next bit (or stop level) now.
                        if (n_cnt == 4'(DBIT - 1)) begin
                            tx_reg <= 1'b1;
                            state  <= STOP;
                        end else begin
                            tx_reg <= shift_next[0];
                        end
                    end else if (s_tick) begin
                        s_cnt <= s_cnt + 5'd1;
                    end
                end
                STOP: begin
                    if (stop_end) begin
                        busy_reg <= 1'b0;
                        state    <= IDLE;
                    end else if (s_tick) begin
                        s_cnt <= s_cnt + 5'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Done is decoded in the last STOP cycle so a start in that cycle is still ignored.
    assign bus.tx_done_tick = (state == STOP) && stop_end;
    assign bus.tx           = tx_reg;
    assign bus.tx_busy      = busy_reg;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Directed bench for uart_tx_framer with BAUD_DIV = 4 (64 clocks per bit).
// dut0 uses a 16-tick stop bit, dut1 a 32-tick stop bit.
module tb_uart_tx_framer;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    logic tx_w   [0:1500];
    logic busy_w [0:1500];
    logic done_w [0:1500];

    uart_tx_framer_if #(.DBIT(8)) bus0 ();
    uart_tx_framer_if #(.DBIT(8)) bus1 ();

    uart_tx_framer #(.DBIT(8), .SB_TICK(16), .BAUD_DIV(4), .DIV_W(2)) dut0 (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .bus        (bus0)
    );

    uart_tx_framer #(.DBIT(8), .SB_TICK(32), .BAUD_DIV(4), .DIV_W(2)) dut1 (
        .clk_100MHz (clk),
        .reset_n    (rst_n),
        .bus        (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Launch leaves time at accepting edge + 1, i.e. inside clock 1 of the frame.
    task automatic launch(input int sel, input logic [7:0] d, input bit hold);
        @(negedge clk);
        if (sel == 0) begin
            bus0.tx_start = 1'b1;
            bus0.tx_din   = d;
        end else begin
            bus1.tx_start = 1'b1;
            bus1.tx_din   = d;
        end
        @(posedge clk);
        #1;
        if (!hold) begin
            bus0.tx_start = 1'b0;
            bus1.tx_start = 1'b0;
        end
    endtask

    // Index k holds the value seen during clock k after the accepting edge.
    task automatic capture(input int sel, input int n);
        for (int k = 1; k <= n; k++) begin
            tx_w[k]   = (sel == 0) ? bus0.tx           : bus1.tx;
            busy_w[k] = (sel == 0) ? bus0.tx_busy      : bus1.tx_busy;
            done_w[k] = (sel == 0) ? bus0.tx_done_tick : bus1.tx_done_tick;
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [7:0] decode(input int s);
        logic [7:0] b;
        for (int i = 0; i < 8; i++) b[i] = tx_w[s + 64 * (1 + i) + 32];
        return b;
    endfunction

    function automatic int count_done(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (done_w[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_busy(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (busy_w[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int count_high(input int lo, input int hi);
        int c = 0;
        for (int k = lo; k <= hi; k++) if (tx_w[k] === 1'b1) c++;
        return c;
    endfunction

    function automatic int first_done(input int lo, input int hi);
        for (int k = lo; k <= hi; k++) if (done_w[k] === 1'b1) return k;
        return -1;
    endfunction

    task automatic test_reset;
        logic [2:0] obs;
        int highs;
        rst_n = 1'b0;
        repeat (5) @(posedge clk);
        @(negedge clk);
        obs = {bus0.tx, bus0.tx_busy, bus0.tx_done_tick};
        total++;
        if (obs !== 3'b100) begin
            bad++;
            $display("FAIL reset_hold: {tx,busy,done} got %b expected 100", obs);
        end
        rst_n = 1'b1;
        @(negedge clk);
        obs = {bus0.tx, bus0.tx_busy, bus0.tx_done_tick};
        total++;
        if (obs !== 3'b100) begin
            bad++;
            $display("FAIL reset_release: {tx,busy,done} got %b expected 100", obs);
        end
        highs = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (bus0.tx === 1'b1 && bus1.tx === 1'b1) highs++;
        end
        total++;
        if (highs !== 100) begin
            bad++;
            $display("FAIL reset_idle_high: got %0d high cycles expected 100", highs);
        end
    endtask

    task automatic test_single_byte;
        logic [7:0]  d;
        logic [63:0] obs;
        logic [63:0] exp;
        logic        eb;
        int          v;
        d = 8'hA5;
        launch(0, d, 1'b0);
        capture(0, 700);
        for (int b = 0; b < 10; b++) begin
            for (int j = 0; j < 64; j++) obs[j] = tx_w[1 + 64 * b + j];
            eb  = (b == 0) ? 1'b0 : (b == 9) ? 1'b1 : d[b - 1];
            exp = {64{eb}};
            total++;
            if (obs !== exp) begin
                bad++;
                $display("FAIL single_bit%0d: got %h expected %h", b, obs, exp);
            end
        end
        v = count_done(1, 700);
        total++;
        if (v !== 1) begin
            bad++;
            $display("FAIL single_done_count: got %0d expected 1", v);
        end
        v = first_done(1, 700);
        total++;
        if (v !== 640) begin
            bad++;
            $display("FAIL single_done_clock: got %0d expected 640", v);
        end
        v = count_busy(1, 700);
        total++;
        if (v !== 640 || busy_w[640] !== 1'b1 || busy_w[641] !== 1'b0) begin
            bad++;
            $display("FAIL single_busy: got %0d busy clocks (last=%b next=%b) expected 640 ending at clock 640",
                     v, busy_w[640], busy_w[641]);
        end
        v = count_high(641, 700);
        total++;
        if (v !== 60) begin
            bad++;
            $display("FAIL single_idle_after: got %0d high clocks expected 60", v);
        end
    endtask

    task automatic test_start_while_busy;
        logic [7:0] got;
        int         v;
        launch(0, 8'h3C, 1'b0);
        fork
            capture(0, 760);
            begin
                repeat (199) @(posedge clk);
                #2;
                bus0.tx_start = 1'b1;
                bus0.tx_din   = 8'hFF;
                @(posedge clk);
                #2;
                bus0.tx_start = 1'b0;
            end
        join
        got = decode(1);
        total++;
        if (got !== 8'h3C) begin
            bad++;
            $display("FAIL busy_decode: got %h expected 3c", got);
        end
        v = count_done(1, 760);
        total++;
        if (v !== 1) begin
            bad++;
            $display("FAIL busy_done_count: got %0d expected 1", v);
        end
        v = count_high(641, 760) + count_busy(641, 760);
        total++;
        if (v !== 120) begin
            bad++;
            $display("FAIL busy_not_queued: got %0d (tx high + busy) expected 120", v);
        end
    endtask

    task automatic test_back_to_back;
        logic [7:0] got;
        int         v;
        launch(0, 8'h00, 1'b1);
        fork
            capture(0, 1400);
            begin
                repeat (299) @(posedge clk);
                #2;
                bus0.tx_din = 8'h55;
                repeat (400) @(posedge clk);
                #2;
                bus0.tx_start = 1'b0;
            end
        join
        got = decode(1);
        total++;
        if (got !== 8'h00) begin
            bad++;
            $display("FAIL b2b_decode1: got %h expected 00", got);
        end
        v = first_done(1, 1400);
        total++;
        if (v !== 640) begin
            bad++;
            $display("FAIL b2b_done1_clock: got %0d expected 640", v);
        end
        total++;
        if ({tx_w[640], tx_w[641], busy_w[641], tx_w[642]} !== 4'b1100) begin
            bad++;
            $display("FAIL b2b_gap: {tx640,tx641,busy641,tx642} got %b expected 1100",
                     {tx_w[640], tx_w[641], busy_w[641], tx_w[642]});
        end
        got = decode(642);
        total++;
        if (got !== 8'h55) begin
            bad++;
            $display("FAIL b2b_decode2: got %h expected 55", got);
        end
        v = first_done(641, 1400);
        total++;
        if (v !== 1281) begin
            bad++;
            $display("FAIL b2b_done2_clock: got %0d expected 1281", v);
        end
        v = count_done(1, 1400);
        total++;
        if (v !== 2) begin
            bad++;
            $display("FAIL b2b_done_count: got %0d expected 2", v);
        end
    endtask

    task automatic test_midframe_reset;
        logic [2:0] obs;
        logic [7:0] got;
        int         v;
        launch(0, 8'h81, 1'b0);
        capture(0, 299);
        #1;
        rst_n = 1'b0;
        #1;
        obs = {bus0.tx, bus0.tx_busy, bus0.tx_done_tick};
        total++;
        if (obs !== 3'b100) begin
            bad++;
            $display("FAIL midreset_async: {tx,busy,done} got %b expected 100", obs);
        end
        v = 0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (bus0.tx_done_tick !== 1'b0) v++;
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus0.tx_done_tick !== 1'b0 || bus0.tx !== 1'b1 || bus0.tx_busy !== 1'b0) v++;
        end
        total++;
        if (v !== 0) begin
            bad++;
            $display("FAIL midreset_quiet: got %0d bad idle cycles expected 0", v);
        end
        launch(0, 8'h7E, 1'b0);
        capture(0, 700);
        got = decode(1);
        total++;
        if (got !== 8'h7E) begin
            bad++;
            $display("FAIL midreset_decode: got %h expected 7e", got);
        end
        v = first_done(1, 700);
        total++;
        if (v !== 640) begin
            bad++;
            $display("FAIL midreset_done_clock: got %0d expected 640", v);
        end
    endtask

    task automatic test_long_stop;
        logic [7:0] got;
        int         v;
        launch(1, 8'hC3, 1'b0);
        capture(1, 760);
        got = decode(1);
        total++;
        if (got !== 8'hC3) begin
            bad++;
            $display("FAIL stop32_decode: got %h expected c3", got);
        end
        v = count_high(577, 704);
        total++;
        if (v !== 128 || busy_w[704] !== 1'b1 || busy_w[705] !== 1'b0) begin
            bad++;
            $display("FAIL stop32_length: got %0d high stop clocks (busy704=%b busy705=%b) expected 128",
                     v, busy_w[704], busy_w[705]);
        end
        v = first_done(1, 760);
        total++;
        if (v !== 704) begin
            bad++;
            $display("FAIL stop32_done_clock: got %0d expected 704", v);
        end
        v = count_busy(1, 760);
        total++;
        if (v !== 704) begin
            bad++;
            $display("FAIL stop32_busy: got %0d expected 704", v);
        end
    endtask

    initial begin
        total         = 0;
        bad           = 0;
        rst_n         = 1'b0;
        bus0.tx_start = 1'b0;
        bus0.tx_din   = '0;
        bus1.tx_start = 1'b0;
        bus1.tx_din   = '0;
        test_reset();
        test_single_byte();
        test_start_while_busy();
        test_back_to_back();
        test_midframe_reset();
        test_long_stop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
